// File: rtl/fifo_pkg.sv
// Shared defaults and sizing helper for the synchronous FIFO.
package fifo_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DEPTH      = 4;

  // Ceiling log2, used to size the read/write pointers and the occupancy count.
  function automatic int ptr_width(input int depth);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < depth) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/fifo_if.sv
// Producer/consumer bundle for the FIFO.
// The FIFO_ERR_FLAGS_EN macro adds the sticky overflow/underflow status signals.
interface fifo_if import fifo_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] din;
  logic [DATA_WIDTH-1:0] dout;
  logic                  full;
  logic                  empty;
`ifdef FIFO_ERR_FLAGS_EN
  logic                  overflow;
  logic                  underflow;
`endif

  // User side: drives requests and write data, observes data and status.
  modport master (
    output wr_en, rd_en, din,
`ifdef FIFO_ERR_FLAGS_EN
    input  overflow, underflow,
`endif
    input  dout, full, empty
  );

  // FIFO side.
  modport slave (
    input  wr_en, rd_en, din,
`ifdef FIFO_ERR_FLAGS_EN
    output overflow, underflow,
`endif
    output dout, full, empty
  );

endinterface

// File: rtl/fifo_mem.sv
// Storage array for the FIFO: synchronous write, combinational read address.
// Contents are deliberately not reset.
module fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int ADDR_W     = 2
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_W-1:0]     i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [ADDR_W-1:0]     i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // Write port: store the incoming word at the write address.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fifo.sv
// Single-clock synchronous FIFO with registered read data.
// Writes while full and reads while empty are ignored.
// Define FIFO_ERR_FLAGS_EN to add sticky overflow/underflow flags.
module fifo import fifo_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH
) (
  input  logic   clk,
  input  logic   rst,
  fifo_if.slave  bus
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]      r_wptr;
  logic [PTR_W-1:0]      r_rptr;
  logic [CNT_W-1:0]      r_count;
  logic [DATA_WIDTH-1:0] r_dout;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_wr_acc;
  logic                  w_rd_acc;

  assign w_full   = (r_count == CNT_W'(DEPTH));
  assign w_empty  = (r_count == '0);
  // Full/empty gating gives the required priority: write wins when empty, read wins when full.
  assign w_wr_acc = bus.wr_en && !w_full;
  assign w_rd_acc = bus.rd_en && !w_empty;

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_W     (PTR_W)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_wr_acc),
    .i_waddr (r_wptr),
    .i_wdata (bus.din),
    .i_raddr (r_rptr),
    .o_rdata (w_rdata)
  );

  // Pointer, occupancy and read-data registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_dout  <= '0;
    end else begin
      if (w_wr_acc) r_wptr <= r_wptr + PTR_W'(1);
      if (w_rd_acc) begin
        r_rptr <= r_rptr + PTR_W'(1);
        r_dout <= w_rdata;
      end
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.dout  = r_dout;
  assign bus.full  = w_full;
  assign bus.empty = w_empty;

`ifdef FIFO_ERR_FLAGS_EN
  logic r_overflow;
  logic r_underflow;

  // Sticky error flags: record any rejected write or read until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (bus.wr_en && w_full)  r_overflow  <= 1'b1;
      if (bus.rd_en && w_empty) r_underflow <= 1'b1;
    end
  end

  assign bus.overflow  = r_overflow;
  assign bus.underflow = r_underflow;
`endif

endmodule

// File: tb/tb_fifo.sv
// Directed self-checking bench for the FIFO (DATA_WIDTH=8, DEPTH=4).
// Inputs change 1 ns after a rising edge; outputs are sampled at the same point.
module tb_fifo;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  fifo_if #(.DATA_WIDTH(8)) bus ();

  fifo #(
    .DATA_WIDTH (8),
    .DEPTH      (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
      $display("tx %-12s observed=0x%02h expected=0x%02h ok", tag, obs, exp);
    else begin
      failures++;
      $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rst         = 1'b0;
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.din     = 8'h00;

    // Reset asserted before any clock edge; values must appear asynchronously.
    #1 rst = 1'b1;
    #2;
    chk("rst_empty", {7'd0, bus.empty}, 8'h01);
    chk("rst_full",  {7'd0, bus.full},  8'h00);
    chk("rst_dout",  bus.dout,          8'h00);
`ifdef FIFO_ERR_FLAGS_EN
    chk("rst_ovf", {7'd0, bus.overflow},  8'h00);
    chk("rst_udf", {7'd0, bus.underflow}, 8'h00);
`endif
    #8 rst = 1'b0;   // released at t=11, reset held 10 ns

    // Fill with four words.
    bus.wr_en = 1'b1; bus.din = 8'h11;
    tick();
    chk("fill1_empty", {7'd0, bus.empty}, 8'h00);
    chk("fill1_full",  {7'd0, bus.full},  8'h00);
    bus.din = 8'h22;
    tick();
    bus.din = 8'h33;
    tick();
    chk("fill3_full",  {7'd0, bus.full},  8'h00);
    bus.din = 8'h44;
    tick();
    chk("fill4_full",  {7'd0, bus.full},  8'h01);
    chk("fill4_empty", {7'd0, bus.empty}, 8'h00);

    // Overflow attempt.
    bus.din = 8'hAA;
    tick();
    bus.wr_en = 1'b0;
    chk("ovf_full", {7'd0, bus.full}, 8'h01);
    chk("ovf_dout", bus.dout, 8'h00);
`ifdef FIFO_ERR_FLAGS_EN
    chk("ovf_flag", {7'd0, bus.overflow},  8'h01);
    chk("ovf_udf",  {7'd0, bus.underflow}, 8'h00);
`endif

    // Drain four words plus one ignored read.
    bus.rd_en = 1'b1;
    tick();
    chk("drain1", bus.dout, 8'h11);
    chk("drain1_full", {7'd0, bus.full}, 8'h00);
    tick();
    chk("drain2", bus.dout, 8'h22);
    tick();
    chk("drain3", bus.dout, 8'h33);
    chk("drain3_empty", {7'd0, bus.empty}, 8'h00);
    tick();
    chk("drain4", bus.dout, 8'h44);
    chk("drain4_empty", {7'd0, bus.empty}, 8'h01);
`ifdef FIFO_ERR_FLAGS_EN
    chk("drain4_udf", {7'd0, bus.underflow}, 8'h00);
`endif
    tick();
    bus.rd_en = 1'b0;
    chk("drain5_hold", bus.dout, 8'h44);
    chk("drain5_empty", {7'd0, bus.empty}, 8'h01);
`ifdef FIFO_ERR_FLAGS_EN
    chk("udf_flag", {7'd0, bus.underflow}, 8'h01);
`endif

    // Wrap: write 3, read 2, then 6 simultaneous cycles keeping one entry.
    bus.wr_en = 1'b1;
    bus.din = 8'h01; tick();
    bus.din = 8'h02; tick();
    bus.din = 8'h03; tick();
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b1;
    tick();
    chk("wrap_rd1", bus.dout, 8'h01);
    tick();
    chk("wrap_rd2", bus.dout, 8'h02);
    bus.wr_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.din = 8'h10 + 8'(i);
      tick();
      chk($sformatf("sim%0d_dout", i), bus.dout, (i == 0) ? 8'h03 : 8'h10 + 8'(i - 1));
      chk($sformatf("sim%0d_empty", i), {7'd0, bus.empty}, 8'h00);
      chk($sformatf("sim%0d_full", i),  {7'd0, bus.full},  8'h00);
    end
    bus.wr_en = 1'b0;
    tick();
    bus.rd_en = 1'b0;
    chk("wrap_last", bus.dout, 8'h15);
    chk("wrap_empty", {7'd0, bus.empty}, 8'h01);

    // Simultaneous request while empty: write only, no read-through.
    bus.wr_en = 1'b1; bus.rd_en = 1'b1; bus.din = 8'h77;
    tick();
    bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    chk("se_dout",  bus.dout, 8'h15);
    chk("se_empty", {7'd0, bus.empty}, 8'h00);
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    chk("se_read", bus.dout, 8'h77);
    chk("se_empty2", {7'd0, bus.empty}, 8'h01);

    // Simultaneous request while full: read only, write dropped.
    bus.wr_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.din = 8'hA1 + 8'(i);
      tick();
    end
    chk("sf_full", {7'd0, bus.full}, 8'h01);
    bus.rd_en = 1'b1; bus.din = 8'h99;
    tick();
    bus.wr_en = 1'b0;
    chk("sf_dout", bus.dout, 8'hA1);
    chk("sf_full2", {7'd0, bus.full}, 8'h00);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("sf_rd%0d", i), bus.dout, 8'hA2 + 8'(i));
    end
    bus.rd_en = 1'b0;
    chk("sf_empty", {7'd0, bus.empty}, 8'h01);

    // Mid-operation reset with two entries stored.
    bus.wr_en = 1'b1;
    bus.din = 8'hB1; tick();
    bus.din = 8'hB2; tick();
    bus.wr_en = 1'b0;
    chk("mr_pre_empty", {7'd0, bus.empty}, 8'h00);
    #1 rst = 1'b1;
    #2;
    chk("mr_empty", {7'd0, bus.empty}, 8'h01);
    chk("mr_full",  {7'd0, bus.full},  8'h00);
    chk("mr_dout",  bus.dout, 8'h00);
`ifdef FIFO_ERR_FLAGS_EN
    chk("mr_ovf", {7'd0, bus.overflow},  8'h00);
    chk("mr_udf", {7'd0, bus.underflow}, 8'h00);
`endif
    #1 rst = 1'b0;
    bus.wr_en = 1'b1; bus.din = 8'h5A;
    tick();
    bus.wr_en = 1'b0;
    chk("mr_wr_empty", {7'd0, bus.empty}, 8'h00);
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    chk("mr_read", bus.dout, 8'h5A);
    chk("mr_end_empty", {7'd0, bus.empty}, 8'h01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo.md
Name: fifo

Overview:
- Single-clock synchronous FIFO buffering DATA_WIDTH-bit words between a producer and consumer in the same clock domain.
- Provides full/empty status flags and a registered read data output.
- Writes to a full FIFO and reads from an empty FIFO are ignored, so neither corrupts state.

Parameters:
- DATA_WIDTH, 8, width of each stored word in bits.
- DEPTH, 4, number of entries; must be a power of two, >= 2.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- wr_en  input  1  write request, sampled at posedge clk.
- rd_en  input  1  read request, sampled at posedge clk.
- din  input  DATA_WIDTH  write data, captured with an accepted write.
- dout  output  DATA_WIDTH  read data; registered.
- full  output  1  high when DEPTH entries are stored.
- empty  output  1  high when 0 entries are stored.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values, applied immediately on rst assertion regardless of clk: write pointer=0, read pointer=0, count=0, dout=0, empty=1, full=0.
- Storage array is not reset. Reset mid-operation discards all stored entries.
- Pointers: write and read pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Occupancy: tracked by a count register of log2(DEPTH)+1 bits, range 0..DEPTH.
- Write accept = wr_en && !full. On acceptance: mem[wptr] <= din; wptr increments.
- Read accept = rd_en && !empty. On acceptance: dout <= mem[rptr]; rptr increments. dout is valid the cycle after the accepting edge (1-cycle latency).
- dout holds its last value when no read is accepted.
- Count update:
  - +1 on write only.
  - -1 on read only.
  - Unchanged when both are accepted, or when neither is.
- Simultaneous wr_en and rd_en:
  - When empty: only the write is accepted. No read-through; the new data is not visible on dout that cycle.
  - When full: only the read is accepted. The write is dropped; the producer must retry.
  - Otherwise: both are accepted.
- Flags: full=(count==DEPTH) and empty=(count==0), both combinational from the registered count. They update the cycle after the accepting edge and are never both high.
- Overflow: write while full is silently dropped; no state changes.
- Underflow: read while empty is silently dropped; dout is unchanged.
- Data ordering: strict first-in first-out across pointer wrap-around.

Optional Feature:
- Macro: FIFO_ERR_FLAGS_EN.
- Defined: adds two outputs, overflow and underflow (1 bit each, reset 0).
  - overflow sets when wr_en && full at a clock edge.
  - underflow sets when rd_en && empty at a clock edge.
  - Both are sticky until rst.
- Not defined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package fifo_pkg holds:
  - Default DATA_WIDTH and DEPTH constants.
  - The pointer-width function (ceiling log2) used to size pointers and count.
- Sub-module fifo_mem:
  - DEPTH x DATA_WIDTH register array with a synchronous write port.
  - Combinational read address; no reset.
- fifo holds pointers, count, flags, dout register and the optional error flags.

Test Plan:
- Reset: assert rst for 10 ns with wr_en=rd_en=0 -> empty=1, full=0, dout=0 asynchronously, before any clock edge.
- Fill: write 0x11, 0x22, 0x33, 0x44 on consecutive edges -> empty falls after the first write; full=1 after the fourth.
- Overflow: with FIFO full, write 0xAA for one cycle -> full stays 1 and contents are unchanged. With FIFO_ERR_FLAGS_EN defined, overflow=1.
- Drain: assert rd_en for 5 cycles -> dout = 0x11, 0x22, 0x33, 0x44 on successive cycles (0xAA never appears).
  - empty=1 after the fourth read.
  - The fifth read is ignored and dout holds 0x44. With FIFO_ERR_FLAGS_EN defined, underflow=1.
- Wrap plus simultaneous access:
  - Write 3 words, read 2, then assert wr_en+rd_en together for 6 cycles with incrementing data -> count stays 1 and order is preserved across pointer wrap.
- Mid-operation reset: with 2 entries stored, pulse rst between clock edges -> empty=1 immediately. A subsequent write of 0x5A followed by a read returns 0x5A.
